// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-only slave in front of a one-cycle-latency memory.
// Each read walks IDLE -> RD -> DATA -> RESP; out-of-range reads skip to RESP with SLVERR.
module axi4_lite_read_slave #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_busy
);

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both high.
    // ARREADY and RVALID come straight from registers, so neither depends on the other side.
    typedef enum logic [1:0] {IDLE, RD, DATA, RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rvalid_q, rvalid_d;

    logic                  ar_in_range;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  unused_latched_bits;

    assign ar_in_range = ~|S_AXI_ARADDR[ADDR_WIDTH-1:MEM_ADDR_BITS];
    assign word_addr   = {{(ADDR_WIDTH-MEM_ADDR_BITS){1'b0}},
                          araddr_q[MEM_ADDR_BITS-1:2], 2'b00};
    // Byte-lane bits and the range bits of the latched address never reach the memory.
    assign unused_latched_bits = ^{araddr_q[ADDR_WIDTH-1:MEM_ADDR_BITS], araddr_q[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            araddr_q <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;
        case (state_q)
            IDLE: begin
                if (S_AXI_ARVALID) begin
                    araddr_d = S_AXI_ARADDR;
                    if (ar_in_range) begin
                        state_d = RD;
                    end else begin
                        state_d  = RESP;
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                        rvalid_d = 1'b1;
                    end
                end
            end
            RD: begin
                addr_d  = word_addr;
                state_d = DATA;
            end
            DATA: begin
                rdata_d  = read_data;
                rresp_d  = RESP_OKAY;
                rvalid_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign S_AXI_ARREADY = (state_q == IDLE);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign mem_read      = (state_q == RD);
    // The word address is live during RD and frozen in addr_q afterwards.
    assign addr          = (state_q == RD) ? word_addr : addr_q;
    assign read_busy     = (state_q != IDLE);

endmodule
